// File: rtl/aes_pkg.sv
// Shared AES widths, scheduler FSM encodings and job record types.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_WORD_W  = 32;
  localparam int AES_WORDS   = AES_BLOCK_W / AES_WORD_W;

  // Word counter value at which a state job substitutes its last word
  localparam logic [1:0] LAST_WORD = 2'(AES_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ST_RUN = 2'd1,
    KS_RUN = 2'd2
  } sched_state_e;

  // Who won the most recent grant; drives the round-robin tie-break
  typedef enum logic {
    GRANT_ST = 1'b0,
    GRANT_KS = 1'b1
  } grant_e;

  // Captured state job: direction plus the working block, which is shifted
  // one word per cycle as words come back from the S-box unit
  typedef struct packed {
    logic                   fwd;
    logic [AES_BLOCK_W-1:0] blk;
  } st_job_t;

endpackage

// File: rtl/sub_word.sv
// Four parallel AES S-boxes (forward or inverse) over one 32-bit word.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
module sub_word
  import aes_pkg::*;
(
  input  logic                  fwd_i,
  input  logic [AES_WORD_W-1:0] word_i,
  output logic [AES_WORD_W-1:0] word_o
);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); 0 maps to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Forward S-box: inverse then affine map with constant 0x63
  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  // Inverse S-box: undo the affine map first, then invert
  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    logic [7:0] v;
    v = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
    return gf_inv(v);
  endfunction

  // Substitute each byte lane in the selected direction
  always_comb begin
    word_o = '0;
    for (int b = 0; b < AES_WORD_W / 8; b++) begin
      word_o[8*b +: 8] = fwd_i ? sbox_fwd(word_i[8*b +: 8]) : sbox_inv(word_i[8*b +: 8]);
    end
  end

endmodule

// File: rtl/sbox_scheduler.sv
// Arbitrates one shared S-box word unit between a 128-bit state requester and a 32-bit key-schedule requester.
// Latency: state accept N -> st_valid_o at N+5; key accept N -> ks_valid_o at N+2.
// Backpressure: readies only high in IDLE, masked by arbitration; jobs run to completion, never preempted.
module sbox_scheduler
  import aes_pkg::*;
#(
  parameter int unsigned KS_FIXED_PRIO = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   st_valid_i,
  input  logic                   st_enc_or_dec_i,
  input  logic [AES_BLOCK_W-1:0] st_data_i,
  output logic                   st_ready_o,
  output logic                   st_valid_o,
  output logic [AES_BLOCK_W-1:0] st_data_o,
  input  logic                   ks_valid_i,
  input  logic [AES_WORD_W-1:0]  ks_word_i,
  output logic                   ks_ready_o,
  output logic                   ks_valid_o,
  output logic [AES_WORD_W-1:0]  ks_word_o,
  output logic                   busy_o
);

  sched_state_e          state_q;
  sched_state_e          state_d;
  logic [1:0]            cnt_q;
  logic [1:0]            cnt_d;
  grant_e                last_grant_q;
  st_job_t               st_job_q;
  logic [AES_WORD_W-1:0] ks_job_q;
  logic                  st_valid_q;
  logic                  ks_valid_q;
  logic [AES_BLOCK_W-1:0] st_res_q;
  logic [AES_WORD_W-1:0] ks_res_q;

  logic                  is_idle;
  logic                  ks_wins_tie;
  logic                  st_acc;
  logic                  ks_acc;
  logic                  sub_fwd;
  logic [AES_WORD_W-1:0] sub_in;
  logic [AES_WORD_W-1:0] sub_out;
  logic [AES_BLOCK_W-1:0] st_shifted;

  assign is_idle     = (state_q == IDLE);
  assign ks_wins_tie = (KS_FIXED_PRIO != 0) || (last_grant_q == GRANT_ST);

  // A requester is refused only when the other one is also asking and wins the tie
  assign st_ready_o = is_idle && (!ks_valid_i || (st_valid_i && !ks_wins_tie));
  assign ks_ready_o = is_idle && (!st_valid_i || ks_wins_tie);
  assign st_acc     = st_valid_i && st_ready_o;
  assign ks_acc     = ks_valid_i && ks_ready_o;

  assign busy_o     = !is_idle;
  assign st_valid_o = st_valid_q;
  assign st_data_o  = st_res_q;
  assign ks_valid_o = ks_valid_q;
  assign ks_word_o  = ks_res_q;

  // Working block after this cycle's word is substituted: top word out, result in at the bottom
  assign st_shifted = {st_job_q.blk[AES_BLOCK_W-AES_WORD_W-1:0], sub_out};

  // FSM state and word counter registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: one cycle per word for state jobs, a single cycle for key jobs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (ks_acc) begin
          state_d = KS_RUN;
        end else if (st_acc) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST_WORD) begin
          state_d = IDLE;
        end
      end
      KS_RUN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Steer the shared S-box: key word (always forward) in KS_RUN, else the state block's top word
  always_comb begin
    sub_in  = st_job_q.blk[AES_BLOCK_W-1 -: AES_WORD_W];
    sub_fwd = st_job_q.fwd;
    if (state_q == KS_RUN) begin
      sub_in  = ks_job_q;
      sub_fwd = 1'b1;
    end
  end

  sub_word u_sub_word (
    .fwd_i  (sub_fwd),
    .word_i (sub_in),
    .word_o (sub_out)
  );

  // Job capture, word-by-word substitution, result registers and one-cycle done pulses
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_grant_q <= GRANT_ST;
      st_job_q     <= '0;
      ks_job_q     <= '0;
      st_valid_q   <= 1'b0;
      ks_valid_q   <= 1'b0;
      st_res_q     <= '0;
      ks_res_q     <= '0;
    end else begin
      st_valid_q <= 1'b0;
      ks_valid_q <= 1'b0;
      if (st_acc) begin
        st_job_q.fwd <= st_enc_or_dec_i;
        st_job_q.blk <= st_data_i;
        last_grant_q <= GRANT_ST;
      end
      if (ks_acc) begin
        ks_job_q     <= ks_word_i;
        last_grant_q <= GRANT_KS;
      end
      if (state_q == ST_RUN) begin
        st_job_q.blk <= st_shifted;
        // After four shifts the words are back in their original order
        if (cnt_q == LAST_WORD) begin
          st_res_q   <= st_shifted;
          st_valid_q <= 1'b1;
        end
      end
      if (state_q == KS_RUN) begin
        ks_res_q   <= sub_out;
        ks_valid_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sbox_scheduler.sv
// Directed bench for sbox_scheduler: table of single jobs plus arbitration, blocking and reset sequences.
// Latency: checks exact pulse cycles (state N+5, key N+2).
// Backpressure: checks ready masking during jobs and tie-breaks for both priority settings.
module tb_sbox_scheduler;

  logic         clk_i = 1'b0;
  logic         rst_n_i = 1'b1;
  logic         st_valid_i = 1'b0;
  logic         st_enc_or_dec_i = 1'b0;
  logic [127:0] st_data_i = '0;
  logic         ks_valid_i = 1'b0;
  logic [31:0]  ks_word_i = '0;

  logic         st_ready_o, st_valid_o, ks_ready_o, ks_valid_o, busy_o;
  logic [127:0] st_data_o;
  logic [31:0]  ks_word_o;
  logic         p1_st_ready, p1_st_valid, p1_ks_ready, p1_ks_valid, p1_busy;
  logic [127:0] p1_st_data;
  logic [31:0]  p1_ks_word;

  always #5 clk_i = ~clk_i;

  sbox_scheduler #(.KS_FIXED_PRIO(0)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .st_valid_i(st_valid_i), .st_enc_or_dec_i(st_enc_or_dec_i), .st_data_i(st_data_i),
    .st_ready_o(st_ready_o), .st_valid_o(st_valid_o), .st_data_o(st_data_o),
    .ks_valid_i(ks_valid_i), .ks_word_i(ks_word_i), .ks_ready_o(ks_ready_o),
    .ks_valid_o(ks_valid_o), .ks_word_o(ks_word_o), .busy_o(busy_o)
  );

  sbox_scheduler #(.KS_FIXED_PRIO(1)) dut_p1 (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .st_valid_i(st_valid_i), .st_enc_or_dec_i(st_enc_or_dec_i), .st_data_i(st_data_i),
    .st_ready_o(p1_st_ready), .st_valid_o(p1_st_valid), .st_data_o(p1_st_data),
    .ks_valid_i(ks_valid_i), .ks_word_i(ks_word_i), .ks_ready_o(p1_ks_ready),
    .ks_valid_o(p1_ks_valid), .ks_word_o(p1_ks_word), .busy_o(p1_busy)
  );

  typedef struct {
    bit           is_ks;
    bit           enc;
    logic [127:0] din;
    logic [127:0] dexp;
    string        name;
  } vec_t;

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

  vec_t         vecs[7];
  int           n_chk = 0;
  int           n_err = 0;
  logic [127:0] exp_st = '0;
  logic [127:0] exp_ks = '0;
  logic [3:0]   g0, g1;
  int           g0n, g1n;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    st_valid_i = 1'b0; ks_valid_i = 1'b0;
    st_enc_or_dec_i = 1'b0; st_data_i = '0; ks_word_i = '0;
    tick();
    tick();
    rst_n_i = 1'b1;
    exp_st = '0;
    exp_ks = '0;
  endtask

  // Issue one job from IDLE, scramble inputs after accept, check exact pulse cycle and held outputs
  task automatic run_job(input vec_t v);
    int lat;
    lat = v.is_ks ? 2 : 5;
    if (v.is_ks) begin
      ks_valid_i = 1'b1; ks_word_i = v.din[31:0];
    end else begin
      st_valid_i = 1'b1; st_enc_or_dec_i = v.enc; st_data_i = v.din;
    end
    #1;
    chk({v.name, " ready"}, v.is_ks ? ks_ready_o : st_ready_o, 1);
    tick();
    st_valid_i = 1'b0; ks_valid_i = 1'b0;
    st_data_i = ~v.din; ks_word_i = ~v.din[31:0]; st_enc_or_dec_i = ~v.enc;
    for (int c = 1; c < lat; c++) begin
      chk({v.name, " busy/no pulse"}, {busy_o, st_valid_o, ks_valid_o}, 3'b100);
      tick();
    end
    chk({v.name, " pulse"}, {busy_o, st_valid_o, ks_valid_o}, v.is_ks ? 3'b001 : 3'b010);
    if (v.is_ks) begin
      chk({v.name, " ks_word"}, ks_word_o, v.dexp);
      chk({v.name, " st_data held"}, st_data_o, exp_st);
      exp_ks = v.dexp;
    end else begin
      chk({v.name, " st_data"}, st_data_o, v.dexp);
      chk({v.name, " ks_word held"}, ks_word_o, exp_ks);
      exp_st = v.dexp;
    end
    tick();
    chk({v.name, " after pulse"}, {st_valid_o, ks_valid_o, st_data_o, ks_word_o[31:0]},
        {2'b00, exp_st, exp_ks[31:0]});
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 128'h0, {16{8'h63}}, "st zero fwd"};
    vecs[1] = '{1'b0, 1'b0, {16{8'h63}}, 128'h0, "st 63 inv"};
    vecs[2] = '{1'b1, 1'b0, 128'hcf4f3c09, 128'h8a84eb01, "ks cf4f3c09"};
    vecs[3] = '{1'b0, 1'b1, FIPS_IN, FIPS_OUT, "st fips fwd"};
    vecs[4] = '{1'b0, 1'b0, FIPS_OUT, FIPS_IN, "st fips inv"};
    vecs[5] = '{1'b1, 1'b0, 128'h01020304, 128'h7c777bf2, "ks 01020304"};
    vecs[6] = '{1'b0, 1'b1, 128'h000102030405060708090a0b0c0d0e0f,
                128'h637c777bf26b6fc53001672bfed7ab76, "st row0 fwd"};

    #1;
    do_reset();
    #1;
    chk("reset outputs", {busy_o, st_valid_o, ks_valid_o, st_data_o, ks_word_o}, '0);
    chk("reset readies", {st_ready_o, ks_ready_o}, 2'b11);

    for (int i = 0; i < 7; i++) run_job(vecs[i]);

    // Both requesters held high: round-robin alternates starting with key; fixed priority always key
    do_reset();
    st_valid_i = 1'b1; st_enc_or_dec_i = 1'b1; st_data_i = '0;
    ks_valid_i = 1'b1; ks_word_i = '0;
    g0 = '0; g1 = '0; g0n = 0; g1n = 0;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (g0n < 4 && ks_ready_o) begin g0[g0n] = 1'b1; g0n++; end
      else if (g0n < 4 && st_ready_o) begin g0[g0n] = 1'b0; g0n++; end
      if (g1n < 4 && p1_ks_ready) begin g1[g1n] = 1'b1; g1n++; end
      else if (g1n < 4 && p1_st_ready) begin g1[g1n] = 1'b0; g1n++; end
      tick();
    end
    st_valid_i = 1'b0; ks_valid_i = 1'b0;
    chk("rr grant count", g0n, 4);
    chk("rr grants KS,ST,KS,ST", g0, 4'b0101);
    chk("fixed grant count", g1n, 4);
    chk("fixed grants all KS", g1, 4'b1111);
    for (int c = 0; c < 6; c++) tick();
    chk("fixed prio st starved", {p1_busy, p1_ks_valid, p1_st_valid, p1_st_data}, '0);
    chk("fixed prio ks word", p1_ks_word, 32'h63636363);

    // Key request during a state job waits for the state pulse cycle
    do_reset();
    st_valid_i = 1'b1; st_enc_or_dec_i = 1'b1; st_data_i = FIPS_IN;
    #1;
    chk("blk st ready", st_ready_o, 1);
    tick();
    st_valid_i = 1'b0; ks_valid_i = 1'b1; ks_word_i = 32'hcf4f3c09;
    for (int c = 1; c < 5; c++) begin
      #1;
      chk("blk ks_ready in ST_RUN", {ks_ready_o, st_valid_o}, 2'b00);
      tick();
    end
    chk("blk st pulse", {st_valid_o, st_data_o}, {1'b1, FIPS_OUT});
    chk("blk ks ready at pulse", ks_ready_o, 1);
    tick();
    ks_valid_i = 1'b0;
    chk("blk ks running", {busy_o, ks_valid_o}, 2'b10);
    tick();
    chk("blk ks result", {ks_valid_o, ks_word_o}, {1'b1, 32'h8a84eb01});
    exp_st = FIPS_OUT; exp_ks = 128'h8a84eb01;
    tick();

    // Reset in cycle N+2 of a state job drops it without a pulse
    st_valid_i = 1'b1; st_enc_or_dec_i = 1'b1; st_data_i = FIPS_IN;
    tick();
    st_valid_i = 1'b0;
    tick();
    rst_n_i = 1'b0;
    #1;
    chk("midjob reset outputs", {busy_o, st_valid_o, ks_valid_o, st_data_o, ks_word_o}, '0);
    tick();
    chk("in reset no pulse", {st_valid_o, busy_o}, 2'b00);
    tick();
    chk("in reset no pulse 2", {st_valid_o, busy_o}, 2'b00);
    rst_n_i = 1'b1;
    exp_st = '0; exp_ks = '0;
    run_job(vecs[3]);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sbox_scheduler.md
SBOX_SCHEDULER -- requirements
Module: sbox_scheduler

Interface
REQ-001 SHALL have parameter: KS_FIXED_PRIO, default 0, 0 = round-robin tie-break, 1 = key-schedule requester always wins ties.
REQ-002 SHALL have port: clk_i  input  1  single clock, all flops rising-edge.
REQ-003 SHALL have port: rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: st_valid_i  input  1  state requester has a 128-bit block to substitute.
REQ-005 SHALL have port: st_enc_or_dec_i  input  1  1 = forward S-box, 0 = inverse S-box, sampled at accept.
REQ-006 SHALL have port: st_data_i  input  128  state block, word0 = [127:96].
REQ-007 SHALL have port: st_ready_o  output  1  state request accepted when st_valid_i & st_ready_o.
REQ-008 SHALL have port: st_valid_o  output  1  one-cycle pulse, st_data_o result valid.
REQ-009 SHALL have port: st_data_o  output  128  substituted block, held until next state result.
REQ-010 SHALL have port: ks_valid_i  input  1  key-schedule requester has one word.
REQ-011 SHALL have port: ks_word_i  input  32  word to substitute, always forward S-box.
REQ-012 SHALL have port: ks_ready_o  output  1  key request accepted when ks_valid_i & ks_ready_o.
REQ-013 SHALL have port: ks_valid_o  output  1  one-cycle pulse, ks_word_o valid.
REQ-014 SHALL have port: ks_word_o  output  32  substituted word, held until next key result.
REQ-015 SHALL have port: busy_o  output  1  high whenever FSM is not IDLE.

Function
REQ-016 SHALL share exactly one 32-bit S-box word unit between both requesters; it is the only substitution logic in the block.
REQ-017 SHALL implement FSM states IDLE, ST_RUN (2-bit word counter 0..3) and KS_RUN.
REQ-018 SHALL drive st_ready_o/ks_ready_o only in IDLE, combinationally masked by arbitration; both low in ST_RUN and KS_RUN.
REQ-019 SHALL, when only one valid is high in IDLE, grant that requester.
REQ-020 SHALL, when both valids are high in IDLE, grant key schedule if KS_FIXED_PRIO=1, else the requester not granted last (last_grant flop).
REQ-021 SHALL, on state accept in cycle N, register st_data_i and st_enc_or_dec_i, then substitute word k in cycle N+1+k (k=0..3) into the result register, and pulse st_valid_o in cycle N+5.
REQ-022 SHALL, on key accept in cycle N, register ks_word_i, substitute it in cycle N+1 with forward S-box, and pulse ks_valid_o in cycle N+2.
REQ-023 SHALL return to IDLE in the cycle the valid_o pulse is asserted, so a new accept can occur in that same cycle (state throughput 1 per 5 cycles, key 1 per 2).
REQ-024 SHALL ignore changes on st_data_i, st_enc_or_dec_i and ks_word_i after accept; an ST_RUN job is never preempted by key requests.
REQ-025 SHALL keep st_data_o/ks_word_o stable between their own valid pulses; a job for the other requester does not disturb them.

Reset
REQ-026 SHALL, on rst_n_i low (any time, including mid-job), force FSM to IDLE, word counter 0, last_grant = state (so key wins first round-robin tie), drop the job, and drive st_valid_o, ks_valid_o, busy_o = 0 and st_data_o = 0, ks_word_o = 0.
REQ-027 SHALL assert no valid_o pulse for a job dropped by reset; first accept possible in the first clock edge after rst_n_i rises.

Structure
REQ-028 SHALL place FSM state encodings and width constants (AES_BLOCK_W=128, AES_WORD_W=32) in shared package aes_pkg.
REQ-029 SHALL instantiate existing sub_word as its single sub-module for the shared S-box; no other sub-modules.

Verification
REQ-030 SHALL test: state 0x000...0, enc_or_dec=1 accepted cycle N -> st_valid_o in N+5 only, st_data_o = 0x6363...63 (16 bytes).
REQ-031 SHALL test: state 0x6363...63, enc_or_dec=0 -> st_data_o = 0x000...0; enc_or_dec toggled mid-job has no effect.
REQ-032 SHALL test: ks_word_i = 0xcf4f3c09 accepted cycle N -> ks_valid_o in N+2, ks_word_o = 0x8a84eb01.
REQ-033 SHALL test: both valids high in IDLE repeatedly, KS_FIXED_PRIO=0 -> grants alternate KS, ST, KS, ...; KS_FIXED_PRIO=1 -> KS always first.
REQ-034 SHALL test: ks_valid_i raised during ST_RUN -> ks_ready_o stays 0 until st_valid_o cycle, then key accepted that cycle.
REQ-035 SHALL test: rst_n_i pulsed low in cycle N+2 of a state job -> outputs 0 immediately, no st_valid_o, busy_o = 0.
